// File: rtl/bus_initiator.sv
// Initiator for the daisy-chained register bus: issues one host request
// into the chain head and reports the echoed rdata or a timeout to the host.
module bus_initiator #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req_addr_i,
    input  logic [15:0] req_wdata_i,
    input  logic        req_rw_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    output logic [15:0] addr_o,
    output logic [15:0] wdata_o,
    output logic [15:0] rdata_o,
    output logic        rw_o,
    output logic        valid_o,
    input  logic [15:0] addr_i,
    input  logic [15:0] wdata_i,
    input  logic [15:0] rdata_i,
    input  logic        rw_i,
    input  logic        valid_i,
    output logic [15:0] resp_rdata_o,
    output logic        resp_timeout_o,
    output logic        resp_valid_o,
    input  logic        resp_ready_i
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, wdata_q, rdata_q;
    logic        rw_q, timeout_q;
    logic [15:0] cnt_q;
    logic        busy, match, expire;
    logic        unused;

    assign unused = ^wdata_i;
    assign busy   = (state_q == ISSUE) || (state_q == WAIT);
    assign match  = valid_i && (addr_i == addr_q) && (rw_i == rw_q);
    assign expire = cnt_q == 16'(TIMEOUT_CYCLES - 1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (req_valid_i) state_d = ISSUE;
            ISSUE,
            WAIT:  begin
                if (match || expire) state_d = RESP;
                else                 state_d = WAIT;
            end
            RESP:  if (resp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rw_q      <= 1'b0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid_i) begin
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                rw_q    <= req_rw_i;
                cnt_q   <= '0;
            end
            // a match on the last allowed cycle takes priority over expiry
            if (busy) begin
                if (match) begin
                    rdata_q   <= rdata_i;
                    timeout_q <= 1'b0;
                end else if (expire) begin
                    rdata_q   <= '0;
                    timeout_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end
        end
    end

    always_comb begin
        req_ready_o    = (state_q == IDLE);
        valid_o        = 1'b0;
        addr_o         = '0;
        wdata_o        = '0;
        rdata_o        = '0;
        rw_o           = 1'b0;
        resp_valid_o   = 1'b0;
        resp_rdata_o   = '0;
        resp_timeout_o = 1'b0;
        if (state_q == ISSUE) begin
            valid_o = 1'b1;
            addr_o  = addr_q;
            wdata_o = wdata_q;
            rw_o    = rw_q;
        end
        if (state_q == RESP) begin
            resp_valid_o   = 1'b1;
            resp_rdata_o   = rdata_q;
            resp_timeout_o = timeout_q;
        end
    end

endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator: register-pipe chain model with one read responder,
// directed scenarios followed by randomized transactions.
module tb_bus_initiator;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req_addr_i, req_wdata_i;
    logic        req_rw_i, req_valid_i, req_ready_o;
    logic [15:0] addr_o, wdata_o, rdata_o;
    logic        rw_o, valid_o;
    logic [15:0] addr_i, wdata_i, rdata_i;
    logic        rw_i, valid_i;
    logic [15:0] resp_rdata_o;
    logic        resp_timeout_o, resp_valid_o, resp_ready_i;

    bus_initiator #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_rw_i(req_rw_i), .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .addr_o(addr_o), .wdata_o(wdata_o), .rdata_o(rdata_o),
        .rw_o(rw_o), .valid_o(valid_o),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i),
        .rw_i(rw_i), .valid_i(valid_i),
        .resp_rdata_o(resp_rdata_o), .resp_timeout_o(resp_timeout_o),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // chain model: pipe of {valid, addr, wdata, rdata, rw}
    logic [49:0] pipe [0:15];
    logic [49:0] tap, head, bus_vec;
    int          n_stages = 3;
    logic [15:0] rsp_addr = 16'h0007;
    logic [15:0] rsp_data = 16'h1234;
    logic        inj_on = 1'b0;
    logic [15:0] inj_addr = '0;
    logic        inj_rw = 1'b0;

    assign bus_vec = {valid_o, addr_o, wdata_o, rdata_o, rw_o};

    always_comb begin
        head = bus_vec;
        if (valid_o && !rw_o && addr_o == rsp_addr)
            head = {1'b1, addr_o, wdata_o, rsp_data, 1'b0};
    end

    always @(posedge clk) begin
        pipe[0] <= head;
        for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
    end

    always_comb begin
        tap = pipe[n_stages-1];
        if (inj_on) tap = {1'b1, inj_addr, 16'h0, 16'hDEAD, inj_rw};
        {valid_i, addr_i, wdata_i, rdata_i, rw_i} = tap;
    end

    task automatic flush(input int cycles);
        inj_on = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("idle", {resp_valid_o, valid_o, req_ready_o}, 3'b001);
        end
    endtask

    task automatic run_txn(input logic [15:0] a, input logic [15:0] wd,
                           input logic rw, input int n, input int hold,
                           input logic hold_req, input int inj_cyc,
                           input logic [15:0] i_addr, input logic i_rw);
        int          exp_cyc, got_cyc;
        logic        exp_to;
        logic [15:0] exp_rd, snap_rd;
        logic        snap_to;
        n_stages = n;
        exp_to   = (1 + n) > T;
        exp_cyc  = exp_to ? T + 1 : 2 + n;
        exp_rd   = (!exp_to && !rw && a == rsp_addr) ? rsp_data : 16'h0;
        inj_addr = i_addr;
        inj_rw   = i_rw;
        got_cyc  = 0;
        @(negedge clk);
        check("req_ready_idle", req_ready_o, 1'b1);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_wdata_i = wd;
        req_rw_i    = rw;
        inj_on      = (inj_cyc == 1);
        for (int k = 1; k <= 40 && got_cyc == 0; k++) begin
            @(negedge clk);
            req_valid_i = 1'b0;
            check("bus", bus_vec,
                  (k == 1) ? {1'b1, a, wd, 16'h0, rw} : 50'h0);
            check("req_ready_busy", req_ready_o, 1'b0);
            if (resp_valid_o) got_cyc = k;
            inj_on = (k + 1 == inj_cyc);
        end
        inj_on = 1'b0;
        check("resp_cycle", got_cyc, exp_cyc);
        check("resp_rdata", resp_rdata_o, exp_rd);
        check("resp_timeout", resp_timeout_o, exp_to);
        snap_rd = resp_rdata_o;
        snap_to = resp_timeout_o;
        req_valid_i = hold_req;
        req_addr_i  = a ^ 16'h0100;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", resp_valid_o, 1'b1);
            check("hold_stable", {resp_rdata_o, resp_timeout_o},
                  {snap_rd, snap_to});
            check("hold_quiet", {req_ready_o, bus_vec}, 51'h0);
        end
        resp_ready_i = 1'b1;
        req_valid_i  = 1'b0;
        @(negedge clk);
        resp_ready_i = 1'b0;
        check("back_idle", {resp_valid_o, req_ready_o}, 2'b01);
    endtask

    initial begin
        rst = 1'b1;
        req_addr_i = '0; req_wdata_i = '0; req_rw_i = 1'b0;
        req_valid_i = 1'b0; resp_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_outputs",
              {req_ready_o, bus_vec, resp_rdata_o, resp_timeout_o,
               resp_valid_o}, {1'b1, 50'h0, 18'h0});
        rst = 1'b0;
        flush(4);

        // write echo, read with responder
        run_txn(16'h0003, 16'h00A5, 1'b1, 3, 0, 1'b0, 0, 16'h0, 1'b0);
        flush(12);
        run_txn(16'h0007, 16'h0000, 1'b0, 3, 0, 1'b0, 0, 16'h0, 1'b0);
        flush(12);
        // no return at all, then boundary returns
        run_txn(16'h0007, 16'h0000, 1'b0, 15, 0, 1'b0, 0, 16'h0, 1'b0);
        flush(12);
        run_txn(16'h0007, 16'h0000, 1'b0, 7, 0, 1'b0, 0, 16'h0, 1'b0);
        flush(12);
        run_txn(16'h0007, 16'h0000, 1'b0, 8, 0, 1'b0, 0, 16'h0, 1'b0);
        flush(12);
        // host stalls the response while a new request waits
        run_txn(16'h0005, 16'h5A5A, 1'b1, 3, 5, 1'b1, 0, 16'h0, 1'b0);
        flush(12);
        // stray in IDLE, then wrong addr and wrong rw while waiting
        @(negedge clk);
        inj_addr = 16'h0007; inj_rw = 1'b0; inj_on = 1'b1;
        flush(2);
        run_txn(16'h0007, 16'h0000, 1'b0, 3, 0, 1'b0, 2, 16'h0009, 1'b0);
        flush(12);
        run_txn(16'h0007, 16'h0000, 1'b0, 5, 1, 1'b0, 3, 16'h0007, 1'b1);
        flush(12);

        // reset during WAIT
        n_stages = 3;
        @(negedge clk);
        req_valid_i = 1'b1; req_addr_i = 16'h0007; req_rw_i = 1'b0;
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_abort",
              {req_ready_o, bus_vec, resp_rdata_o, resp_timeout_o,
               resp_valid_o}, {1'b1, 50'h0, 18'h0});
        flush(12);
        run_txn(16'h0007, 16'h0000, 1'b0, 2, 0, 1'b0, 0, 16'h0, 1'b0);
        flush(12);

        // randomized transactions
        for (int t = 0; t < 25; t++) begin
            logic [15:0] a;
            int          n;
            int          ic;
            a = ($urandom_range(0, 1) == 1) ? 16'h0007
                                            : 16'($urandom_range(0, 15));
            rsp_data = 16'($urandom);
            n  = $urandom_range(1, 10);
            ic = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0;
            run_txn(a, 16'($urandom), 1'($urandom), n,
                    $urandom_range(0, 3), 1'($urandom), ic,
                    a ^ 16'h8000, 1'($urandom));
            flush(12);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
